// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable modulus, per-cycle step, wrap/saturate modes,
// synchronous clear and load, and overflow/underflow pulse plus sticky reporting.
module updown_counter_mod #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH - 1,
    parameter int STEP_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load_n,
    input  logic [WIDTH-1:0]  data_load,
    input  logic              ce,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic              sat_mode,
    input  logic              sticky_clr,
    output logic [WIDTH-1:0]  count_out,
    output logic              max_count,
    output logic              zero,
    output logic              wrap_pulse,
    output logic              ovf_sticky,
    output logic              unf_sticky
);

    if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_max_val
        $fatal(1, "updown_counter_mod: MAX_VAL out of range 1..2**WIDTH-1");
    end
    if (2**STEP_W - 1 > MAX_VAL + 1) begin : g_bad_step_w
        $fatal(1, "updown_counter_mod: STEP_W too wide for the modulus");
    end

    // One extra bit so sums and wrap corrections are never truncated before the range compare.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MAX_VAL + 1);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic             unf_sticky_q, unf_sticky_d;
    logic             ovf, unf;

    logic [WIDTH:0] count_ext, step_ext, data_ext, sum_ext;
    assign count_ext = {1'b0, count_q};
    assign step_ext  = (WIDTH+1)'(step);
    assign data_ext  = {1'b0, data_load};
    assign sum_ext   = count_ext + step_ext;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        count_d = count_q;
        ovf     = 1'b0;
        unf     = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (!load_n) begin
            count_d = (data_ext > MAX_EXT) ? MAX_W : data_load;
        end else if (ce && step != '0) begin
            if (up_down) begin
                if (sum_ext <= MAX_EXT) begin
                    count_d = sum_ext[WIDTH-1:0];
                end else begin
                    ovf     = 1'b1;
                    count_d = sat_mode ? MAX_W : WIDTH'(sum_ext - MOD_EXT);
                end
            end else begin
                if (step_ext <= count_ext) begin
                    count_d = WIDTH'(count_ext - step_ext);
                end else begin
                    unf     = 1'b1;
                    count_d = sat_mode ? '0 : WIDTH'(count_ext + (MOD_EXT - step_ext));
                end
            end
        end
        wrap_d       = ovf | unf;
        // A new event beats a same-cycle clear of the sticky flags.
        ovf_sticky_d = (ovf_sticky_q & ~sticky_clr) | ovf;
        unf_sticky_d = (unf_sticky_q & ~sticky_clr) | unf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            count_q      <= '0;
            wrap_q       <= 1'b0;
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            wrap_q       <= wrap_d;
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
        end
    end

    assign count_out  = count_q;
    assign max_count  = (count_q == MAX_W);
    assign zero       = (count_q == '0);
    assign wrap_pulse = wrap_q;
    assign ovf_sticky = ovf_sticky_q;
    assign unf_sticky = unf_sticky_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench for updown_counter_mod: driver pushes model expectations,
// a monitor pops and compares one entry per clock after the edge.
module tb_updown_counter_mod;

    localparam int WIDTH  = 4;
    localparam int MAX    = 9;
    localparam int STEP_W = 2;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              load_n;
    logic [WIDTH-1:0]  data_load;
    logic              ce;
    logic              up_down;
    logic [STEP_W-1:0] step;
    logic              sat_mode;
    logic              sticky_clr;
    logic [WIDTH-1:0]  count_out;
    logic              max_count;
    logic              zero;
    logic              wrap_pulse;
    logic              ovf_sticky;
    logic              unf_sticky;

    updown_counter_mod #(.WIDTH(WIDTH), .MAX_VAL(MAX), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .load_n     (load_n),
        .data_load  (data_load),
        .ce         (ce),
        .up_down    (up_down),
        .step       (step),
        .sat_mode   (sat_mode),
        .sticky_clr (sticky_clr),
        .count_out  (count_out),
        .max_count  (max_count),
        .zero       (zero),
        .wrap_pulse (wrap_pulse),
        .ovf_sticky (ovf_sticky),
        .unf_sticky (unf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int count;
        bit wrap;
        bit ovf;
        bit unf;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state: the count as a plain integer in 0..MAX.
    int m_count = 0;
    bit m_ovf   = 0;
    bit m_unf   = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input bit c, input bit ld_n, input int d, input bit en,
                         input bit ud, input int st, input bit sat, input bit sc);
        bit o;
        bit u;
        int s;
        o = 0;
        u = 0;
        clr        = c;
        load_n     = ld_n;
        data_load  = WIDTH'(d);
        ce         = en;
        up_down    = ud;
        step       = STEP_W'(st);
        sat_mode   = sat;
        sticky_clr = sc;
        if (c) begin
            m_count = 0;
        end else if (!ld_n) begin
            m_count = (d > MAX) ? MAX : d;
        end else if (en && st != 0) begin
            s = ud ? m_count + st : m_count - st;
            if (s > MAX) begin
                o = 1;
                m_count = sat ? MAX : s - (MAX + 1);
            end else if (s < 0) begin
                u = 1;
                m_count = sat ? 0 : s + (MAX + 1);
            end else begin
                m_count = s;
            end
        end
        m_ovf = (m_ovf && !sc) || o;
        m_unf = (m_unf && !sc) || u;
        sb.push_back('{m_count, o || u, m_ovf, m_unf});
        @(negedge clk);
    endtask

    task automatic idle();
        apply(0, 1, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_count"}, int'(count_out), 0);
        check({tag, "_zero"}, int'(zero), 1);
        check({tag, "_max"}, int'(max_count), 0);
        check({tag, "_wrap"}, int'(wrap_pulse), 0);
        check({tag, "_ovf"}, int'(ovf_sticky), 0);
        check({tag, "_unf"}, int'(unf_sticky), 0);
    endtask

    // Monitor: the counter presents a new result after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_count", int'(count_out), e.count);
                check("sb_max_count", int'(max_count), int'(e.count == MAX));
                check("sb_zero", int'(zero), int'(e.count == 0));
                check("sb_wrap_pulse", int'(wrap_pulse), int'(e.wrap));
                check("sb_ovf_sticky", int'(ovf_sticky), int'(e.ovf));
                check("sb_unf_sticky", int'(unf_sticky), int'(e.unf));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clr = 0; load_n = 1; data_load = '0; ce = 0; up_down = 1;
        step = '0; sat_mode = 0; sticky_clr = 0;
        #2;
        reset_checks("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap up from 8 by 3 -> 1.
        apply(0, 0, 8, 0, 1, 0, 0, 0);
        apply(0, 1, 0, 1, 1, 3, 0, 0);
        check("wrap_up_count", int'(count_out), 1);
        check("wrap_up_pulse", int'(wrap_pulse), 1);
        idle();
        check("wrap_up_pulse_drop", int'(wrap_pulse), 0);
        check("wrap_up_ovf_holds", int'(ovf_sticky), 1);

        // Wrap down from 1 by 3 -> 8; saturate down from 1 -> 0.
        apply(0, 1, 0, 1, 0, 3, 0, 0);
        check("wrap_down_count", int'(count_out), 8);
        check("wrap_down_unf", int'(unf_sticky), 1);
        apply(0, 0, 1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 1, 0, 3, 1, 0);
        check("sat_down_count", int'(count_out), 0);
        check("sat_down_pulse", int'(wrap_pulse), 1);

        // Reset mid-count, asserted between edges with sticky flags set.
        apply(0, 0, 5, 0, 1, 0, 0, 0);
        idle();
        #2;
        check("pre_reset_count", int'(count_out), 5);
        rst_n = 1'b0;
        #1;
        reset_checks("mid_reset");
        m_count = 0;
        m_ovf   = 0;
        m_unf   = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Saturate hold at MAX.
        apply(0, 0, 9, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 0, 1, 1, 2, 1, 0);
            check("sat_hold_count", int'(count_out), 9);
            check("sat_hold_max", int'(max_count), 1);
            check("sat_hold_pulse", int'(wrap_pulse), 1);
        end

        // Priority: clr beats load and count; then clamped load.
        apply(1, 0, 7, 1, 1, 3, 0, 0);
        check("prio_clr_count", int'(count_out), 0);
        apply(0, 0, 15, 1, 1, 3, 0, 0);
        check("load_clamp_count", int'(count_out), 9);
        check("load_clamp_pulse", int'(wrap_pulse), 0);

        // Sticky collision, then plain sticky clear, then step 0.
        apply(0, 1, 0, 1, 1, 1, 0, 1);
        check("collide_ovf_set", int'(ovf_sticky), 1);
        apply(0, 1, 0, 0, 1, 0, 0, 1);
        check("sticky_clr_ovf", int'(ovf_sticky), 0);
        apply(0, 1, 0, 1, 1, 0, 0, 0);
        check("step0_count", int'(count_out), 0);
        check("step0_pulse", int'(wrap_pulse), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            apply($urandom_range(0, 19) == 0,
                  !($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 15)),
                  $urandom_range(0, 9) != 0,
                  1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) == 0);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
